census_disparity_search: RTL
============================

// Module: census_disparity_search
// PURPOSE
//  Parametrised successor to the census correlator: per left-image census vector, searches MAX_DISP
//  right-image candidates by Hamming distance, LANES candidates per cycle, and reports the winning
//  disparity, its cost and a uniqueness flag. It sits between the census transform and the disparity
//  writer. A ready/valid input handshake replaces the fixed input cadence.
// PARAMETERS
//  CENSUS_W     72   census vector width (bits)
//  MAX_DISP     64   candidates searched, d = 0..MAX_DISP-1 (power of 2)
//  LANES        8    candidates evaluated per cycle; MAX_DISP % LANES == 0
//  DISP_W       6    disparity width, = clog2(MAX_DISP)
//  COST_W       7    cost width, = clog2(CENSUS_W+1)
//  COORD_W      10   pixel coordinate width
//  UNIQ_MARGIN  0    minimum (second_best - best) for out_unique; 0 => always 1
// PORTS
//  clk            in   1          clock
//  reset          in   1          asynchronous, active-low reset
//  left_bitvec    in   CENSUS_W   left census at (input_x,input_y)
//  right_bitvec   in   CENSUS_W   right census at same coordinate
//  bitvec_val     in   1          input valid
//  bitvec_rdy     out  1          block can accept input
//  input_x        in   COORD_W    column of input pixel
//  input_y        in   COORD_W    row of input pixel
//  disparity_val  out  1          one-cycle result pulse
//  disparity      out  DISP_W     winning d
//  out_cost       out  COST_W     Hamming cost of winner
//  out_unique     out  1          uniqueness test passed
//  out_x, out_y   out  COORD_W    coordinate of result
// BEHAVIOUR
//  - Reset (reset==0, async): all outputs 0 except bitvec_rdy=1 after release; FSM->IDLE; history cleared.
//  - Transfer on posedge clk when bitvec_val && bitvec_rdy; producer holds data until transfer.
//  - History: MAX_DISP-deep shift register of right vectors. On transfer: if input_x==0 all entries
//    cleared first; then hist[0]<=right_bitvec, hist[k]<=hist[k-1]. hist[d] = right(x-d).
//  - Candidate d valid iff d <= input_x; invalid lanes never update best/second.
//  - cost(d) = popcount(left ^ hist[d]), COST_W bits, range 0..CENSUS_W.
//  - FSM IDLE: bitvec_rdy=1. On transfer latch left, x, y; d_base<=0; best=second=all-ones -> SEARCH.
//  - SEARCH: bitvec_rdy=0. Evaluate d_base..d_base+LANES-1 in ascending d order; per valid lane:
//    cost<best => second<=best, best<=cost, bestd<=d; else cost<second => second<=cost.
//    Ties keep the smaller d. d_base+=LANES; after MAX_DISP/LANES cycles -> DONE (fixed count, no early exit).
//  - DONE: disparity_val=1 for exactly one cycle with disparity=bestd, out_cost=best, out_x/out_y latched;
//    out_unique = (UNIQ_MARGIN==0) || (second - best >= UNIQ_MARGIN); second all-ones (single valid
//    candidate) counts as a pass. Next cycle -> IDLE.
//  - Latency: transfer edge T -> disparity_val high in cycle T+MAX_DISP/LANES+1 (9 at defaults).
//    Throughput: one pixel per MAX_DISP/LANES+2 cycles.
//  - Result outputs hold their value until the next DONE; disparity_val low outside DONE.
//  - bitvec_val while bitvec_rdy==0: no effect, no history shift.
//  - input_y change has no effect on history; only input_x==0 clears it.
//  - Reset mid-SEARCH: no disparity_val pulse; block returns to IDLE with empty history.
// TESTING
//  1 Reset pulse low -> all outputs 0, bitvec_rdy=1 after release; bitvec_val during reset ignored.
//  2 x=0, left=0, right=72'hFF..FF -> disparity=0, out_cost=72, out_unique=1, disparity_val 9 cycles after transfer.
//  3 Row x=0..20, right(x)=distinct patterns; left at x=20 equals right(7) -> disparity=13, out_cost=0.
//  4 Row ramp: right gains one '1' bit per pixel, left=0; at x=10 -> disparity=10 (lowest cost); all-equal history -> disparity=0 (tie rule).
//  5 UNIQ_MARGIN=4, best=0, second=3 -> out_unique=0; same stimulus UNIQ_MARGIN=2 -> out_unique=1.
//  6 bitvec_val held high during SEARCH -> no extra transfer/shift, bitvec_rdy=0; reset low mid-SEARCH -> no disparity_val, bitvec_rdy=1 after release.

Source files
------------

// File: rtl/census_disparity_search_if.sv
// Producer/consumer bundle for the census disparity search: a ready/valid census input plus the
// registered result outputs.
interface census_disparity_search_if #(
    parameter int CENSUS_W = 72,
    parameter int DISP_W   = 6,
    parameter int COST_W   = 7,
    parameter int COORD_W  = 10
);
    logic [CENSUS_W-1:0] left_bitvec;
    logic [CENSUS_W-1:0] right_bitvec;
    logic                bitvec_val;
    logic                bitvec_rdy;
    logic [COORD_W-1:0]  input_x;
    logic [COORD_W-1:0]  input_y;
    logic                disparity_val;
    logic [DISP_W-1:0]   disparity;
    logic [COST_W-1:0]   out_cost;
    logic                out_unique;
    logic [COORD_W-1:0]  out_x;
    logic [COORD_W-1:0]  out_y;

    modport master (
        output left_bitvec, right_bitvec, bitvec_val, input_x, input_y,
        input  bitvec_rdy, disparity_val, disparity, out_cost, out_unique, out_x, out_y
    );

    modport slave (
        input  left_bitvec, right_bitvec, bitvec_val, input_x, input_y,
        output bitvec_rdy, disparity_val, disparity, out_cost, out_unique, out_x, out_y
    );
endinterface

// File: rtl/census_disparity_search.sv
// Searches MAX_DISP right-image census candidates for each left census vector, LANES per cycle,
// and reports the lowest-Hamming-cost disparity with its cost and a uniqueness flag.
module census_disparity_search #(
    parameter int CENSUS_W    = 72,
    parameter int MAX_DISP    = 64,
    parameter int LANES       = 8,
    parameter int DISP_W      = 6,
    parameter int COST_W      = 7,
    parameter int COORD_W     = 10,
    parameter int UNIQ_MARGIN = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    census_disparity_search_if.slave io_bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

    state_t              r_state;
    logic                r_rdy;
    logic [CENSUS_W-1:0] r_left;
    logic [COORD_W-1:0]  r_x;
    logic [COORD_W-1:0]  r_y;
    logic [DISP_W-1:0]   r_dbase;
    logic [COST_W-1:0]   r_best;
    logic [COST_W-1:0]   r_second;
    logic [DISP_W-1:0]   r_bestd;
    logic [CENSUS_W-1:0] r_hist [MAX_DISP];

    logic                r_val;
    logic [DISP_W-1:0]   r_disp;
    logic [COST_W-1:0]   r_cost;
    logic                r_unique;
    logic [COORD_W-1:0]  r_out_x;
    logic [COORD_W-1:0]  r_out_y;

    logic                w_xfer;
    logic [DISP_W-1:0]   w_lane_d   [LANES];
    logic                w_lane_ok  [LANES];
    logic [COST_W-1:0]   w_lane_cost[LANES];
    logic [COST_W-1:0]   w_best;
    logic [COST_W-1:0]   w_second;
    logic [DISP_W-1:0]   w_bestd;
    logic [COST_W-1:0]   w_margin;
    logic                w_unique;
    logic                w_last;

    function automatic logic [COST_W-1:0] popcount(input logic [CENSUS_W-1:0] v);
        logic [COST_W-1:0] c;
        c = '0;
        for (int i = 0; i < CENSUS_W; i++) begin
            c = c + COST_W'(v[i]);
        end
        return c;
    endfunction

    assign w_xfer = io_bus.bitvec_val && r_rdy && (r_state == S_IDLE);
    assign w_last = (r_dbase == DISP_W'(MAX_DISP - LANES));

    // Lanes beyond the current column have no real right pixel behind them.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_lane_d[gi]    = r_dbase + DISP_W'(gi);
        assign w_lane_ok[gi]   = (COORD_W'(w_lane_d[gi]) <= r_x);
        assign w_lane_cost[gi] = popcount(r_left ^ r_hist[w_lane_d[gi]]);
    end

    // Lanes fold in ascending d, so a strict '<' keeps the smaller d on ties.
    always_comb begin
        w_best   = r_best;
        w_second = r_second;
        w_bestd  = r_bestd;
        for (int i = 0; i < LANES; i++) begin
            if (w_lane_ok[i]) begin
                if (w_lane_cost[i] < w_best) begin
                    w_second = w_best;
                    w_best   = w_lane_cost[i];
                    w_bestd  = w_lane_d[i];
                end else if (w_lane_cost[i] < w_second) begin
                    w_second = w_lane_cost[i];
                end
            end
        end
    end

    assign w_margin = r_second - r_best;
    assign w_unique = (UNIQ_MARGIN == 0) || (r_second == '1) || (int'(w_margin) >= UNIQ_MARGIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rdy    <= 1'b0;
            r_left   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_dbase  <= '0;
            r_best   <= '1;
            r_second <= '1;
            r_bestd  <= '0;
            r_val    <= 1'b0;
            r_disp   <= '0;
            r_cost   <= '0;
            r_unique <= 1'b0;
            r_out_x  <= '0;
            r_out_y  <= '0;
            for (int k = 0; k < MAX_DISP; k++) begin
                r_hist[k] <= '0;
            end
        end else begin
            r_val <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_rdy    <= 1'b0;
                        r_left   <= io_bus.left_bitvec;
                        r_x      <= io_bus.input_x;
                        r_y      <= io_bus.input_y;
                        r_dbase  <= '0;
                        r_best   <= '1;
                        r_second <= '1;
                        r_bestd  <= '0;
                        r_state  <= S_SEARCH;
                        // Column 0 starts a new row: older entries shift in as zeros.
                        r_hist[0] <= io_bus.right_bitvec;
                        for (int k = 1; k < MAX_DISP; k++) begin
                            r_hist[k] <= (io_bus.input_x == '0) ? '0 : r_hist[k-1];
                        end
                    end else begin
                        r_rdy <= 1'b1;
                    end
                end
                S_SEARCH: begin
                    r_best   <= w_best;
                    r_second <= w_second;
                    r_bestd  <= w_bestd;
                    r_dbase  <= r_dbase + DISP_W'(LANES);
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_val    <= 1'b1;
                    r_disp   <= r_bestd;
                    r_cost   <= r_best;
                    r_unique <= w_unique;
                    r_out_x  <= r_x;
                    r_out_y  <= r_y;
                    r_rdy    <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.bitvec_rdy    = r_rdy;
    assign io_bus.disparity_val = r_val;
    assign io_bus.disparity     = r_disp;
    assign io_bus.out_cost      = r_cost;
    assign io_bus.out_unique    = r_unique;
    assign io_bus.out_x         = r_out_x;
    assign io_bus.out_y         = r_out_y;
endmodule
